// File: rtl/div_8bit.sv
`default_nettype none
// ============================================================================
// Module   : div_8bit
// Purpose  : Multi-cycle unsigned restoring divider, one quotient bit per clock
// Revision : 1.0 - initial release
// ============================================================================
module div_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DZERO = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   prem_q, prem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic [WIDTH:0]     w_shifted;
    logic [WIDTH-1:0]   w_diff;
    logic               w_cout;
    logic               w_carry;

    // The restored remainder is always below the divisor, so it fits in WIDTH
    // bits; only the shifted trial value needs the extra bit. A set MSB in the
    // shifted value means it already exceeds any divisor (no borrow possible).
    always_comb begin
        w_shifted         = {prem_q, shift_q[WIDTH-1]};
        {w_cout, w_diff}  = {1'b0, w_shifted[WIDTH-1:0]} + {1'b0, ~dsr_q}
                          + {{WIDTH{1'b0}}, 1'b1};
        w_carry           = w_shifted[WIDTH] | w_cout;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = dividend;
                    dsr_d   = divisor;
                    prem_d  = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = (divisor == '0) ? S_DZERO : S_RUN;
                end
            end
            S_RUN: begin
                prem_d  = w_carry ? w_diff : w_shifted[WIDTH-1:0];
                shift_d = {shift_q[WIDTH-2:0], w_carry};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = shift_d;
                    rem_d   = prem_d;
                    dz_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DZERO: begin
                quot_d  = '1;
                rem_d   = shift_q;
                dz_d    = 1'b1;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_div_8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_8bit
// Purpose  : Self-checking bench for div_8bit against an arithmetic model
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_8bit;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    div_8bit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from idle and wait (bounded) for done.
    // lat = cycles from the accepting edge to done, -1 if done never came.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        lat = -1; busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dz=%b q=%0d r=%0d, expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int lat, bc;
        run_op(8'd111, 8'd42, lat, bc);
        n_checks++;
        if (lat !== WIDTH) begin n_fail++; $display("FAIL nominal_latency: got %0d expected %0d", lat, WIDTH); end
        n_checks++;
        if (bc !== WIDTH) begin n_fail++; $display("FAIL nominal_busy_cycles: got %0d expected %0d", bc, WIDTH); end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd2, 8'd27, 1'b0}) begin
            n_fail++;
            $display("FAIL nominal_result: got q=%0d r=%0d dz=%b expected q=2 r=27 dz=0", quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL nominal_done_width: done=%b expected 0 one cycle later", done); end
    endtask

    task automatic test_extremes();
        logic [WIDTH-1:0] a_t[3] = '{8'd255, 8'd5, 8'd128};
        logic [WIDTH-1:0] b_t[3] = '{8'd1,   8'd9, 8'd128};
        int lat, bc;
        for (int i = 0; i < 3; i++) begin
            run_op(a_t[i], b_t[i], lat, bc);
            n_checks++;
            if ({quotient, remainder} !== {a_t[i] / b_t[i], a_t[i] % b_t[i]} || lat !== WIDTH) begin
                n_fail++;
                $display("FAIL extreme_%0d/%0d: got q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d",
                         a_t[i], b_t[i], quotient, remainder, lat,
                         a_t[i] / b_t[i], a_t[i] % b_t[i], WIDTH);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat, bc;
        run_op(8'd200, 8'd0, lat, bc);
        n_checks++;
        if (lat !== 1 || bc !== 1) begin
            n_fail++;
            $display("FAIL dz_timing: got lat=%0d busy=%0d expected lat=1 busy=1", lat, bc);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd200, 1'b1}) begin
            n_fail++;
            $display("FAIL dz_result: got q=%0d r=%0d dz=%b expected q=255 r=200 dz=1", quotient, remainder, div_by_zero);
        end
        run_op(8'd200, 8'd7, lat, bc);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {8'd28, 8'd4, 1'b0} || lat !== WIDTH) begin
            n_fail++;
            $display("FAIL dz_recover: got q=%0d r=%0d dz=%b lat=%0d expected q=28 r=4 dz=0 lat=%0d",
                     quotient, remainder, div_by_zero, lat, WIDTH);
        end
    endtask

    task automatic test_start_while_busy();
        int n_done = 0;
        logic [WIDTH-1:0] q_seen = '0, r_seen = '0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd3;
        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin dividend = 8'd50; divisor = 8'd5; end
            if (done) begin n_done++; q_seen = quotient; r_seen = remainder; end
        end
        n_checks++;
        if (n_done !== 1) begin n_fail++; $display("FAIL busy_start_done_count: got %0d expected 1", n_done); end
        n_checks++;
        if ({q_seen, r_seen} !== {8'd33, 8'd1}) begin
            n_fail++;
            $display("FAIL busy_start_result: got q=%0d r=%0d expected q=33 r=1", q_seen, r_seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        @(negedge clk);
        start = 1'b1; dividend = 8'd69; divisor = 8'd4;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
        end
        n_checks++;
        if ({done, quotient, remainder} !== {1'b1, 8'd17, 8'd1}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b q=%0d r=%0d expected done=1 q=17 r=1", done, quotient, remainder);
        end
        start = 1'b1; dividend = 8'd42; divisor = 8'd5;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1 && {quotient, remainder} !== {8'd17, 8'd1}) begin
                n_checks++; n_fail++;
                $display("FAIL b2b_hold: got q=%0d r=%0d expected q=17 r=1", quotient, remainder);
            end
            if (done) begin lat = k; break; end
        end
        n_checks++;
        if ({quotient, remainder} !== {8'd8, 8'd2} || lat !== WIDTH) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d expected q=8 r=2 lat=%0d", quotient, remainder, lat, WIDTH);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0;
        int lat, bc;
        @(negedge clk);
        start = 1'b1; dividend = 8'd250; divisor = 8'd7;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3) rst = 1'b1;
        end
        @(negedge clk);
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b dz=%b q=%0d r=%0d expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", n_done); end
        run_op(8'd250, 8'd7, lat, bc);
        n_checks++;
        if ({quotient, remainder} !== {8'd35, 8'd5} || lat !== WIDTH) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: got q=%0d r=%0d lat=%0d expected q=35 r=5 lat=%0d", quotient, remainder, lat, WIDTH);
        end
    endtask

    task automatic test_random();
        int lat, bc, exp_lat;
        logic [WIDTH-1:0] a, b, eq, er;
        logic edz;
        for (int i = 0; i < 60; i++) begin
            a = WIDTH'($urandom);
            b = (i % 8 == 7) ? '0 : WIDTH'($urandom_range(0, 255));
            edz     = (b == 0);
            eq      = edz ? {WIDTH{1'b1}} : a / b;
            er      = edz ? a : a % b;
            exp_lat = edz ? 1 : WIDTH;
            run_op(a, b, lat, bc);
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== {eq, er, edz} || lat !== exp_lat || bc !== exp_lat) begin
                n_fail++;
                $display("FAIL random_%0d/%0d: got q=%0d r=%0d dz=%b lat=%0d busy=%0d expected q=%0d r=%0d dz=%b lat=%0d",
                         a, b, quotient, remainder, div_by_zero, lat, bc, eq, er, edz, exp_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_extremes();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
